// File: rtl/insn_loader.sv
// insn_loader: boot-time instruction-memory writer.
// Takes a framed byte stream (16-bit count, then count x LEN_INSN/8 payload bytes
// MSB first) and writes the assembled words to instruction memory from address 0.
// The core is held in reset (cpu_rst low) until the image has been written.
// Optional feature: define INSN_LOADER_CHECKSUM_EN to expect a trailing XOR
// checksum byte covering every header and payload byte.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_HDR_HI  | waiting for instruction count, high byte
// S_HDR_LO  | waiting for instruction count, low byte; range-checks count
// S_PAYLOAD | assembling payload bytes into words, one write per word
// S_CKSUM   | waiting for checksum byte (checksum build only)
// S_FLUSH   | one idle cycle so done follows the last write (no-checksum build)
// S_DONE    | image loaded, core released
// S_ERROR   | load aborted (oversize count or checksum mismatch)

module insn_loader #(
    parameter int LEN_INSN = 32,
    parameter int LEN_ADDR = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    input  logic                start,
    output logic                mem_we,
    output logic [LEN_ADDR-1:0] mem_addr,
    output logic [LEN_INSN-1:0] mem_wdata,
    output logic                cpu_rst,
    output logic                done,
    output logic                error
);

    localparam int BYTES = LEN_INSN / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    // Count arithmetic is 17 bits wide so a full memory (2^LEN_ADDR words) is legal.
    localparam logic [16:0] MAX_N = 17'd1 << LEN_ADDR;

    typedef enum logic [2:0] {
        S_HDR_HI  = 3'd0,
        S_HDR_LO  = 3'd1,
        S_PAYLOAD = 3'd2,
`ifdef INSN_LOADER_CHECKSUM_EN
        S_CKSUM   = 3'd3,
`else
        S_FLUSH   = 3'd3,
`endif
        S_DONE    = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    state_t              state_q, state_nx;
    logic [15:0]         count_q;
    logic [16:0]         widx_q;
    logic [BCW-1:0]      byte_cnt_q;
    logic [LEN_INSN-1:0] asm_q;
    logic [LEN_INSN-1:0] asm_nx;
`ifdef INSN_LOADER_CHECKSUM_EN
    logic [7:0]          cksum_q;
`endif

    logic        accept;
    logic        last_byte;
    logic        wr_fire;
    logic        restart;
    logic        ready_nx;
    logic [16:0] n_hdr;

    // Next assembly word: shift the new byte in at the bottom (MSB-first stream).
    generate
        if (BYTES == 1) begin : g_one_byte
            assign asm_nx = rx_data;
        end else begin : g_multi_byte
            assign asm_nx = {asm_q[LEN_INSN-9:0], rx_data};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_HDR_HI;
        end else begin
            state_q <= state_nx;
        end
    end

    // Next-state decode plus the strobes the datapath needs this cycle.
    always_comb begin
        state_nx  = state_q;
        accept    = rx_valid && rx_ready;
        last_byte = (byte_cnt_q == BCW'(BYTES - 1));
        n_hdr     = {1'b0, count_q[15:8], rx_data};
        wr_fire   = 1'b0;
        restart   = 1'b0;
        ready_nx  = 1'b0;

        case (state_q)
            S_HDR_HI: begin
                if (accept) state_nx = S_HDR_LO;
            end
            S_HDR_LO: begin
                if (accept) begin
                    if (n_hdr > MAX_N) begin
                        state_nx = S_ERROR;
                    end else if (n_hdr == 17'd0) begin
`ifdef INSN_LOADER_CHECKSUM_EN
                        state_nx = S_CKSUM;
`else
                        state_nx = S_DONE;
`endif
                    end else begin
                        state_nx = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (accept && last_byte) begin
                    wr_fire = 1'b1;
                    if (widx_q + 17'd1 == {1'b0, count_q}) begin
`ifdef INSN_LOADER_CHECKSUM_EN
                        state_nx = S_CKSUM;
`else
                        state_nx = S_FLUSH;
`endif
                    end
                end
            end
`ifdef INSN_LOADER_CHECKSUM_EN
            S_CKSUM: begin
                if (accept) state_nx = (rx_data == cksum_q) ? S_DONE : S_ERROR;
            end
`else
            S_FLUSH: begin
                state_nx = S_DONE;
            end
`endif
            S_DONE, S_ERROR: begin
                if (start) begin
                    state_nx = S_HDR_HI;
                    restart  = 1'b1;
                end
            end
            default: state_nx = S_HDR_HI;
        endcase

        case (state_nx)
            S_HDR_HI, S_HDR_LO, S_PAYLOAD: ready_nx = 1'b1;
`ifdef INSN_LOADER_CHECKSUM_EN
            S_CKSUM:                       ready_nx = 1'b1;
`endif
            default:                       ready_nx = 1'b0;
        endcase
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_ready <= 1'b0;
            done     <= 1'b0;
            cpu_rst  <= 1'b0;
            error    <= 1'b0;
        end else begin
            rx_ready <= ready_nx;
            done     <= (state_nx == S_DONE);
            cpu_rst  <= (state_nx == S_DONE);
            error    <= (state_nx == S_ERROR);
        end
    end

    // Header capture, word assembly and write index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= '0;
            widx_q     <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
        end else if (restart) begin
            widx_q     <= '0;
            byte_cnt_q <= '0;
        end else if (accept) begin
            case (state_q)
                S_HDR_HI: count_q[15:8] <= rx_data;
                S_HDR_LO: count_q[7:0]  <= rx_data;
                S_PAYLOAD: begin
                    asm_q <= asm_nx;
                    if (last_byte) begin
                        byte_cnt_q <= '0;
                        widx_q     <= widx_q + 17'd1;
                    end else begin
                        byte_cnt_q <= byte_cnt_q + BCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory write port: strobe for one cycle, address/data held until the next write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= wr_fire;
            if (wr_fire) begin
                mem_addr  <= widx_q[LEN_ADDR-1:0];
                mem_wdata <= asm_nx;
            end
        end
    end

`ifdef INSN_LOADER_CHECKSUM_EN
    // Running XOR of every header and payload byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cksum_q <= '0;
        end else if (restart) begin
            cksum_q <= '0;
        end else if (accept && (state_q != S_CKSUM)) begin
            cksum_q <= cksum_q ^ rx_data;
        end
    end
`endif

endmodule

// File: tb/tb_insn_loader.sv
// Bench for insn_loader (LEN_INSN=32, LEN_ADDR=10). Follows INSN_LOADER_CHECKSUM_EN
// so the same frames are correct in either build.
`timescale 1ns/1ps

module tb_insn_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        start = 1'b0;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;

    insn_loader #(.LEN_INSN(32), .LEN_ADDR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .start     (start),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    endtask

    typedef struct {
        string       name;
        logic [7:0]  hi;
        logic [7:0]  lo;
        int          n;
        logic [31:0] w [4];
        int          max_gap;
        bit          poke_start;
        bit          exp_err;
    } vec_t;

    logic [41:0] exp_q [$];
    int cyc = 0;
    int last_acc_cyc = -1;
    int last_we_cyc = -1;
    int done_cyc = -1;
    int err_cyc = -1;
    int we_count = 0;
    logic prev_we = 1'b0, prev_done = 1'b0, prev_err = 1'b0;

    // Edge counter and byte-acceptance tracker (sees pre-edge values).
    always @(posedge clk) begin
        cyc++;
        if (rst && rx_valid && rx_ready) last_acc_cyc = cyc;
    end

    // Write monitor / scoreboard consumer.
    always @(negedge clk) begin
        logic [41:0] item;
        if (rst) begin
            if (mem_we) begin
                we_count++;
                last_we_cyc = cyc;
                check("we_single_cycle", prev_we, 1'b0);
                check("we_latency", cyc, last_acc_cyc);
                check("write_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    item = exp_q.pop_front();
                    check("write_addr_data", {mem_addr, mem_wdata}, item);
                end
            end
            if (done && !prev_done) done_cyc = cyc;
            if (error && !prev_err) err_cyc = cyc;
        end
        prev_we   = mem_we;
        prev_done = done;
        prev_err  = error;
    end

    function automatic logic [31:0] word_of(input vec_t v, input int i);
        logic [15:0] k;
        k = 16'(i);
        return (i < 4) ? v.w[i] : {k, ~k};
    endfunction

    function automatic int pick_gap(input vec_t v);
        return (v.max_gap > 0) ? int'($urandom_range(v.max_gap, 0)) : 0;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        @(negedge clk);
        for (int i = 0; i < gap; i++) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("rx_ready_timeout", rx_ready, 1'b1);
        @(posedge clk);
    endtask

    task automatic send_frame(input vec_t v, input logic [7:0] ck_flip);
        logic [7:0]  ck;
        logic [31:0] w;
        int bi;
        ck = v.hi ^ v.lo;
        send_byte(v.hi, 0);
        send_byte(v.lo, pick_gap(v));
        bi = 0;
        for (int i = 0; i < v.n; i++) begin
            w = word_of(v, i);
            for (int b = 3; b >= 0; b--) begin
                logic [7:0] by;
                by = w[b*8 +: 8];
                ck ^= by;
                if (b == 0) exp_q.push_back({10'(i), w});
                if (v.poke_start && bi == 3) start = 1'b1;
                send_byte(by, pick_gap(v));
                start = 1'b0;
                bi++;
            end
        end
`ifdef INSN_LOADER_CHECKSUM_EN
        if (!v.exp_err) send_byte(ck ^ ck_flip, pick_gap(v));
`else
        if (ck_flip != 8'h00) ck = ck ^ ck_flip;
`endif
    endtask

    task automatic wait_end(input string nm);
        int t;
        t = 0;
        @(negedge clk);
        rx_valid = 1'b0;
        while (!(done || error) && t < 200) begin
            @(negedge clk);
            t++;
        end
        #1;
        if (t >= 200) check({nm, "_end_timeout"}, 1'b0, 1'b1);
    endtask

    task automatic clear_book();
        we_count = 0;
        done_cyc = -1;
        err_cyc  = -1;
    endtask

    task automatic restart_load(input string nm);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({nm, "_restart_done"}, done, 1'b0);
        check({nm, "_restart_error"}, error, 1'b0);
        check({nm, "_restart_ready"}, rx_ready, 1'b1);
        check({nm, "_restart_cpu_rst"}, cpu_rst, 1'b0);
        clear_book();
    endtask

    vec_t vecs [7];
    vec_t normal;

    initial begin
        int exp_done;
        vecs[0] = '{"normal",   8'h00, 8'h02, 2,    '{32'hDEADBEEF, 32'h01234567, 32'h0, 32'h0}, 0, 1'b0, 1'b0};
        vecs[1] = '{"stalled",  8'h00, 8'h02, 2,    '{32'hDEADBEEF, 32'h01234567, 32'h0, 32'h0}, 3, 1'b1, 1'b0};
        vecs[2] = '{"empty",    8'h00, 8'h00, 0,    '{32'h0, 32'h0, 32'h0, 32'h0},               0, 1'b0, 1'b0};
        vecs[3] = '{"three",    8'h00, 8'h03, 3,    '{32'hCAFEF00D, 32'h00000000, 32'hFFFFFFFF, 32'h0}, 2, 1'b0, 1'b0};
        vecs[4] = '{"oversize", 8'h04, 8'h01, 0,    '{32'h0, 32'h0, 32'h0, 32'h0},               0, 1'b0, 1'b1};
        vecs[5] = '{"full_mem", 8'h04, 8'h00, 1024, '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00}, 0, 1'b0, 1'b0};
        vecs[6] = '{"one",      8'h00, 8'h01, 1,    '{32'hA5A55A5A, 32'h0, 32'h0, 32'h0},        1, 1'b0, 1'b0};
        normal = vecs[0];

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rx_ready", rx_ready, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 10'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_cpu_rst", cpu_rst, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        rst = 1'b1;
        #1;
        check("rel_ready_before_edge", rx_ready, 1'b0);
        @(posedge clk);
        #1;
        check("rel_ready_after_edge", rx_ready, 1'b1);
        check("rel_cpu_rst", cpu_rst, 1'b0);

        // Table-driven frames, restarting the loader between them
        for (int k = 0; k < 7; k++) begin
            clear_book();
            send_frame(vecs[k], 8'h00);
            wait_end(vecs[k].name);
            check({vecs[k].name, "_done"}, done, !vecs[k].exp_err);
            check({vecs[k].name, "_cpu_rst"}, cpu_rst, !vecs[k].exp_err);
            check({vecs[k].name, "_error"}, error, vecs[k].exp_err);
            check({vecs[k].name, "_rx_ready"}, rx_ready, 1'b0);
            check({vecs[k].name, "_writes"}, we_count, vecs[k].n);
            check({vecs[k].name, "_queue_empty"}, exp_q.size(), 0);
            if (vecs[k].exp_err) begin
                check({vecs[k].name, "_err_cycle"}, err_cyc, last_acc_cyc);
            end else begin
`ifdef INSN_LOADER_CHECKSUM_EN
                exp_done = last_acc_cyc;
`else
                exp_done = (vecs[k].n == 0) ? last_acc_cyc : last_we_cyc + 1;
`endif
                check({vecs[k].name, "_done_cycle"}, done_cyc, exp_done);
                if (vecs[k].max_gap == 0 && vecs[k].n > 0)
                    check({vecs[k].name, "_done_after_we"}, done_cyc, last_we_cyc + 1);
            end
            // done/error hold, start must be honoured
            repeat (2) @(negedge clk);
            check({vecs[k].name, "_hold"}, {done, error}, {!vecs[k].exp_err, vecs[k].exp_err});
            restart_load(vecs[k].name);
        end

`ifdef INSN_LOADER_CHECKSUM_EN
        // Bad checksum, then restart and a clean load from address 0
        send_frame(normal, 8'h01);
        wait_end("badck");
        check("badck_writes", we_count, 2);
        check("badck_error", error, 1'b1);
        check("badck_cpu_rst", cpu_rst, 1'b0);
        check("badck_done", done, 1'b0);
        check("badck_err_cycle", err_cyc, last_acc_cyc);
        restart_load("badck");
        send_frame(normal, 8'h00);
        wait_end("badck_reload");
        check("badck_reload_done", done, 1'b1);
        check("badck_reload_writes", we_count, 2);
        restart_load("badck_reload");
`endif

        // Reset mid-payload aborts; next frame realigns at address 0
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hBE, 0);
        @(negedge clk);
        rx_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("midrst_rx_ready", rx_ready, 1'b0);
        check("midrst_mem_we", mem_we, 1'b0);
        check("midrst_addr", mem_addr, 10'h0);
        @(negedge clk);
        rst = 1'b1;
        clear_book();
        send_frame(normal, 8'h00);
        wait_end("midrst_reload");
        check("midrst_reload_done", done, 1'b1);
        check("midrst_reload_writes", we_count, 2);
        check("midrst_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
